// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/grant bundle for the register-file write arbiter.
// Two requesters in, one register-file write port and contention count out.
interface regfile_wb_arbiter_if;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [15:0] conflict_cnt;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  wr_en, wr_addr, wr_data, conflict_cnt
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output wr_en, wr_addr, wr_data, conflict_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ALU/load writeback arbiter into a single register-file write port.
// WB_RR_EN selects round-robin; otherwise the load requester always wins.
module regfile_wb_arbiter (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);
  logic        both;
  logic        g0;
  logic        g1;
  logic        acc;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  assign both = bus.req0_valid & bus.req1_valid;

`ifdef WB_RR_EN
  logic last_grant;

  // last_grant high means requester 1 won the previous transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     last_grant <= 1'b1;
    else if (g0) last_grant <= 1'b0;
    else if (g1) last_grant <= 1'b1;
  end

  assign g0 = !rst & bus.req0_valid
            & (!bus.req1_valid | last_grant);
`else
  assign g0 = !rst & bus.req0_valid & !bus.req1_valid;
`endif

  assign g1  = !rst & bus.req1_valid & !g0;
  assign acc = g0 | g1;

  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;

  always_comb begin
    sel_addr = bus.req1_addr;
    sel_data = bus.req1_data;
    unique case (1'b1)
      g0: begin
        sel_addr = bus.req0_addr;
        sel_data = bus.req0_data;
      end
      default: ;
    endcase
  end

  // x0 writes are consumed but never enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= 5'd0;
      bus.wr_data <= 32'h0;
    end else begin
      bus.wr_en <= acc & (sel_addr != 5'd0);
      if (acc) begin
        bus.wr_addr <= sel_addr;
        bus.wr_data <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.conflict_cnt <= 16'h0;
    else if (both && bus.conflict_cnt != 16'hFFFF)
      bus.conflict_cnt <= bus.conflict_cnt + 16'd1;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter.
// Expectations track WB_RR_EN the same way the design build does.
module tb_regfile_wb_arbiter;
  typedef struct packed {
    logic        en;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   vectors = 0;
  int   errors  = 0;
  wr_t  q[$];
  wr_t  held;
  logic m_last;
  int   m_cnt;

  task automatic model_reset;
    q.delete();
    held   = '0;
    m_last = 1'b1;
    m_cnt  = 0;
  endtask

  task automatic model_cycle(output logic g0, output logic g1);
    logic v0, v1;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
`ifdef WB_RR_EN
    g0 = v0 && (!v1 || m_last);
`else
    g0 = v0 && !v1;
`endif
    g1 = v1 && !g0;
    if (v0 && v1 && m_cnt < 65535) m_cnt++;
    if (g0) begin
      q.push_back({bus.req0_addr != 5'd0, bus.req0_addr, bus.req0_data});
      m_last = 1'b0;
    end else if (g1) begin
      q.push_back({bus.req1_addr != 5'd0, bus.req1_addr, bus.req1_data});
      m_last = 1'b1;
    end
  endtask

  task automatic model_out(output wr_t e);
    if (q.size() > 0) begin
      e    = q.pop_front();
      held = e;
    end else begin
      e = {1'b0, held.a, held.d};
    end
  endtask

  task automatic idle_inputs;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_addr  = 5'd0;
    bus.req1_addr  = 5'd0;
    bus.req0_data  = 32'h0;
    bus.req1_data  = 32'h0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_addr  = 5'd3;
    bus.req1_addr  = 5'd4;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b want 00",
               {bus.req0_ready, bus.req1_ready});
    end
    vectors++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== 38'h0) begin
      errors++;
      $display("FAIL reset_wr: got en=%0b a=%0d d=%h want 0",
               bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    vectors++;
    if (bus.conflict_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %h want 0", bus.conflict_cnt);
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic g0, g1;
    wr_t  e;
    for (int i = 0; i < 3; i++) begin
      bus.req0_valid = (i == 0);
      bus.req0_addr  = 5'd5;
      bus.req0_data  = 32'hDEADBEEF;
      #1;
      model_cycle(g0, g1);
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== {g0, g1}) begin
        errors++;
        $display("FAIL single_grant c%0d: got %b want %b", i,
                 {bus.req0_ready, bus.req1_ready}, {g0, g1});
      end
      @(posedge clk); #1;
      model_out(e);
      vectors++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== e) begin
        errors++;
        $display("FAIL single_wr c%0d: got %0b/%0d/%h want %0b/%0d/%h",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, e.en, e.a, e.d);
      end
    end
    idle_inputs();
  endtask

  task automatic test_contention;
    logic       g0, g1;
    wr_t        e;
    logic [3:0] gseq;
    logic [3:0] want;
    logic       saw0;
    do_reset();
    gseq = '0;
    saw0 = 1'b0;
`ifdef WB_RR_EN
    want = 4'b1010;
`else
    want = 4'b1111;
`endif
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_addr  = 5'd1;
    bus.req1_addr  = 5'd2;
    bus.req0_data  = 32'hA000_0000;
    bus.req1_data  = 32'hB000_0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      model_cycle(g0, g1);
      gseq[i] = bus.req1_ready;
      saw0    = saw0 | bus.req0_ready;
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== {g0, g1}) begin
        errors++;
        $display("FAIL cont_grant c%0d: got %b want %b", i,
                 {bus.req0_ready, bus.req1_ready}, {g0, g1});
      end
      @(posedge clk); #1;
      model_out(e);
      vectors++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== e) begin
        errors++;
        $display("FAIL cont_wr c%0d: got %0b/%0d/%h want %0b/%0d/%h",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, e.en, e.a, e.d);
      end
      if (g0) bus.req0_data = bus.req0_data + 32'd1;
      if (g1) bus.req1_data = bus.req1_data + 32'd1;
    end
    idle_inputs();
    vectors++;
    if (gseq !== want) begin
      errors++;
      $display("FAIL cont_order: got %b want %b", gseq, want);
    end
`ifndef WB_RR_EN
    vectors++;
    if (saw0 !== 1'b0) begin
      errors++;
      $display("FAIL cont_fixed_r0: got %b want 0", saw0);
    end
`endif
    vectors++;
    if (bus.conflict_cnt !== 16'd4) begin
      errors++;
      $display("FAIL cont_cnt: got %0d want 4", bus.conflict_cnt);
    end
  endtask

  task automatic test_x0;
    logic g0, g1;
    wr_t  e;
    for (int i = 0; i < 2; i++) begin
      bus.req1_valid = (i == 0);
      bus.req1_addr  = 5'd0;
      bus.req1_data  = 32'h1234;
      #1;
      model_cycle(g0, g1);
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== {g0, g1}) begin
        errors++;
        $display("FAIL x0_grant c%0d: got %b want %b", i,
                 {bus.req0_ready, bus.req1_ready}, {g0, g1});
      end
      @(posedge clk); #1;
      model_out(e);
      vectors++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== e) begin
        errors++;
        $display("FAIL x0_wr c%0d: got %0b/%0d/%h want %0b/%0d/%h",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, e.en, e.a, e.d);
      end
    end
    idle_inputs();
  endtask

  task automatic test_same_addr;
    logic        g0, g1;
    wr_t         e;
    logic [31:0] last_d;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_addr  = 5'd9;
    bus.req1_addr  = 5'd9;
    bus.req0_data  = 32'h0000_0111;
    bus.req1_data  = 32'h0000_0222;
    last_d = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      model_cycle(g0, g1);
      if (g0) last_d = bus.req0_data;
      if (g1) last_d = bus.req1_data;
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== {g0, g1}) begin
        errors++;
        $display("FAIL same_grant c%0d: got %b want %b", i,
                 {bus.req0_ready, bus.req1_ready}, {g0, g1});
      end
      @(posedge clk); #1;
      model_out(e);
      vectors++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== e) begin
        errors++;
        $display("FAIL same_wr c%0d: got %0b/%0d/%h want %0b/%0d/%h",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, e.en, e.a, e.d);
      end
      if (g0) bus.req0_valid = 1'b0;
      if (g1) bus.req1_valid = 1'b0;
    end
    idle_inputs();
    vectors++;
    if (bus.wr_data !== last_d) begin
      errors++;
      $display("FAIL same_persist: got %h want %h", bus.wr_data, last_d);
    end
  endtask

  task automatic test_back_to_back;
    logic g0, g1;
    wr_t  e;
    int   ens;
    ens = 0;
    for (int i = 0; i < 8; i++) begin
      bus.req0_valid = 1'b1;
      bus.req0_addr  = 5'(i + 10);
      bus.req0_data  = $urandom;
      #1;
      model_cycle(g0, g1);
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== {g0, g1}) begin
        errors++;
        $display("FAIL b2b_grant c%0d: got %b want %b", i,
                 {bus.req0_ready, bus.req1_ready}, {g0, g1});
      end
      @(posedge clk); #1;
      model_out(e);
      if (bus.wr_en === 1'b1) ens++;
      vectors++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== e) begin
        errors++;
        $display("FAIL b2b_wr c%0d: got %0b/%0d/%h want %0b/%0d/%h",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, e.en, e.a, e.d);
      end
    end
    idle_inputs();
    vectors++;
    if (ens != 8) begin
      errors++;
      $display("FAIL b2b_rate: got %0d writes want 8", ens);
    end
  endtask

  task automatic test_reset_mid;
    logic g0, g1;
    wr_t  e;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd7;
    bus.req0_data  = 32'h0000_AAAA;
    #1;
    model_cycle(g0, g1);
    @(posedge clk); #1;
    model_out(e);
    vectors++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== e) begin
      errors++;
      $display("FAIL mid_wr: got %0b/%0d/%h want %0b/%0d/%h",
               bus.wr_en, bus.wr_addr, bus.wr_data, e.en, e.a, e.d);
    end
    bus.req1_valid = 1'b1;
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({bus.wr_en, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
      errors++;
      $display("FAIL mid_async: got en/r0/r1=%b want 000",
               {bus.wr_en, bus.req0_ready, bus.req1_ready});
    end
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== 38'h0) begin
      errors++;
      $display("FAIL mid_release: got %0b/%0d/%h want 0/0/0",
               bus.wr_en, bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_saturation;
    logic g0, g1;
    wr_t  e;
    int   bad;
    bad = 0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_addr  = 5'd12;
    bus.req1_addr  = 5'd13;
    for (int i = 0; i < 65540; i++) begin
      #1;
      model_cycle(g0, g1);
      @(posedge clk); #1;
      model_out(e);
      if (bus.conflict_cnt !== 16'(m_cnt)) bad++;
    end
    idle_inputs();
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sat_track: %0d cycles off model, want 0", bad);
    end
    vectors++;
    if (bus.conflict_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_final: got %h want ffff", bus.conflict_cnt);
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    @(posedge clk); #1;
    test_single();
    test_contention();
    test_x0();
    test_same_addr();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Port clk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-002 Port rst, input, 1: asynchronous reset, active-high; SHALL force all state to reset values immediately, independent of clk.
REQ-003 Ports req0_valid/req1_valid, input, 1 each: requester 0 (ALU writeback) / requester 1 (load writeback) holds a write.
REQ-004 Ports req0_addr/req1_addr, input, 5 each: destination register index.
REQ-005 Ports req0_data/req1_data, input, 32 each: destination write data.
REQ-006 Ports req0_ready/req1_ready, output, 1 each: grant; a transfer occurs in any cycle where valid and ready are both high.
REQ-007 Port wr_en, output, 1: register-file write enable.
REQ-008 Port wr_addr, output, 5: register-file write index.
REQ-009 Port wr_data, output, 32: register-file write data.
REQ-010 Port conflict_cnt, output, 16: saturating count of contention cycles.

Function
REQ-011 At most one of req0_ready/req1_ready SHALL be high in any cycle.
REQ-012 reqN_ready SHALL be combinational from the valids and the priority flop: single valid -> that requester granted; no valid -> both ready low.
REQ-013 Both valid -> grant the requester not granted last (round-robin); priority flop last_grant SHALL update only on an accepted transfer.
REQ-014 A requester SHALL hold valid, addr and data stable until accepted; the arbiter SHALL not depend on deassertion before acceptance.
REQ-015 An accepted transfer SHALL appear on wr_addr/wr_data at the next rising edge, with wr_en high for exactly that one cycle (latency 1).
REQ-016 Accepted transfer with addr 5'd0 SHALL be consumed (ready high) but SHALL leave wr_en low; wr_addr/wr_data SHALL still update.
REQ-017 No accepted transfer in a cycle -> wr_en low next cycle; wr_addr/wr_data SHALL hold their previous values.
REQ-018 Back-to-back acceptance SHALL be sustained: one write per cycle, no bubble.
REQ-019 Both requesters targeting the same addr SHALL be written in grant order on consecutive cycles; the later grant's data persists.
REQ-020 conflict_cnt SHALL increment by 1 every cycle in which both valids are high, saturating at 16'hFFFF without wrap.
REQ-021 wr_en/wr_addr/wr_data SHALL be driven directly from flops.

Reset
REQ-022 On rst: wr_en=0, wr_addr=5'd0, wr_data=32'h0, conflict_cnt=16'h0, last_grant=requester 1, so requester 0 wins the first contention.
REQ-023 rst asserted mid-transfer SHALL discard the in-flight write: wr_en low throughout reset and in the first cycle after release, unless a new transfer is accepted in the release cycle.
REQ-024 While rst is high, req0_ready and req1_ready SHALL be low.

Configuration
REQ-025 Macro WB_RR_EN defined: arbitration per REQ-013 (round-robin).
REQ-026 WB_RR_EN undefined: fixed priority; requester 1 (load) SHALL always win contention; last_grant flop removed; all other requirements unchanged.

Verification
REQ-027 Reset: assert rst with both valids high -> both ready low, wr_en=0, conflict_cnt=0, wr_addr=0, wr_data=0.
REQ-028 Single write: req0 valid, addr 5, data 32'hDEADBEEF for 1 cycle -> req0_ready=1 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF; following cycle wr_en=0.
REQ-029 Contention, WB_RR_EN defined: both valid 4 cycles (req0 addr 1, req1 addr 2, held until accepted) -> grants 0,1,0,1; wr_addr sequence 1,2,1,2; conflict_cnt=4.
REQ-030 x0 drop: req1 valid, addr 0, data 32'h1234 -> req1_ready=1; next cycle wr_en=0, wr_addr=0.
REQ-031 Fixed priority, WB_RR_EN undefined: both valid 3 cycles -> req1 granted all 3, req0_ready stays 0.
REQ-032 Saturation: both valid for 65540 cycles -> conflict_cnt=16'hFFFF with no wrap to 0.
